// File: rtl/cordic_vec_responder.sv
// Iterative vectoring-mode CORDIC responder, one micro-rotation per clock.
// Returns gain-compensated magnitude, rotation directions, quadrant and angle.
module cordic_vec_responder #(
    parameter int DATA_WIDTH    = 32,
    parameter int CORDIC_WIDTH  = 38,
    parameter int CORDIC_STAGES = 16,
    parameter int ANGLE_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     vec_en,
    input  logic [DATA_WIDTH-1:0]    vec_xin,
    input  logic [DATA_WIDTH-1:0]    vec_yin,
    input  logic                     vec_angle_calc_en,
    output logic                     busy,
    output logic                     vec_opvld,
    output logic [DATA_WIDTH-1:0]    vec_xout,
    output logic [CORDIC_STAGES-1:0] vec_microRot_out,
    output logic                     vec_microRot_out_start,
    output logic [1:0]               vec_quad_out,
    output logic [ANGLE_WIDTH-1:0]   vec_angle_out
);
    localparam int FRAC   = 4;
    localparam int CNT_W  = (CORDIC_STAGES > 1) ? $clog2(CORDIC_STAGES) : 1;
    localparam int PROD_W = CORDIC_WIDTH + 17;
    localparam int SCL_W  = PROD_W - 20;
    localparam int EXT_W  = CORDIC_WIDTH - DATA_WIDTH;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CORDIC_STAGES - 1);
    localparam logic signed [16:0] K_GAIN = 17'sh09B75;
    localparam logic [ANGLE_WIDTH-1:0] HALF_TURN =
        {1'b1, {(ANGLE_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] POS_MAX =
        {1'b0, {(DATA_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, ITER, COMP} state_t;

    state_t                          r_state;
    logic signed [CORDIC_WIDTH-1:0]  r_x;
    logic signed [CORDIC_WIDTH-1:0]  r_y;
    logic [ANGLE_WIDTH-1:0]          r_z;
    logic [CNT_W-1:0]                r_cnt;
    logic [CORDIC_STAGES-1:0]        r_rot;
    logic [1:0]                      r_quad;
    logic                            r_aen;
    logic                            r_zero;
    logic                            r_busy;
    logic                            r_opvld;
    logic                            r_start;
    logic [DATA_WIDTH-1:0]           r_xout;
    logic [CORDIC_STAGES-1:0]        r_rot_out;
    logic [1:0]                      r_quad_out;
    logic [ANGLE_WIDTH-1:0]          r_ang_out;

    logic signed [CORDIC_WIDTH-1:0]  w_xext;
    logic signed [CORDIC_WIDTH-1:0]  w_yext;
    logic signed [CORDIC_WIDTH-1:0]  w_xabs;
    logic signed [CORDIC_WIDTH-1:0]  w_yabs;
    logic signed [CORDIC_WIDTH-1:0]  w_xsh;
    logic signed [CORDIC_WIDTH-1:0]  w_ysh;
    logic signed [CORDIC_WIDTH-1:0]  w_xnx;
    logic signed [CORDIC_WIDTH-1:0]  w_ynx;
    logic [ANGLE_WIDTH-1:0]          w_znx;
    logic [ANGLE_WIDTH-1:0]          w_atan;
    logic [CORDIC_STAGES-1:0]        w_rot_nx;
    logic                            w_dir;
    logic signed [PROD_W-1:0]        w_prod;
    logic [SCL_W-1:0]                w_scl;
    logic [DATA_WIDTH-1:0]           w_mag;
    logic [ANGLE_WIDTH-1:0]          w_ang;

    // Arctangent table, pi = 2^(ANGLE_WIDTH-1), values for a 16-bit angle.
    function automatic logic [ANGLE_WIDTH-1:0] atan_lut(
        input logic [CNT_W-1:0] i
    );
        int v;
        case (int'(i))
            0:       v = 8192;
            1:       v = 4836;
            2:       v = 2555;
            3:       v = 1297;
            4:       v = 651;
            5:       v = 326;
            6:       v = 163;
            7:       v = 81;
            8:       v = 41;
            9:       v = 20;
            10:      v = 10;
            11:      v = 5;
            12:      v = 3;
            13:      v = 1;
            14:      v = 1;
            default: v = 0;
        endcase
        return ANGLE_WIDTH'(v);
    endfunction

    assign w_xext = {{EXT_W{vec_xin[DATA_WIDTH-1]}}, vec_xin};
    assign w_yext = {{EXT_W{vec_yin[DATA_WIDTH-1]}}, vec_yin};
    assign w_xabs = vec_xin[DATA_WIDTH-1] ? -w_xext : w_xext;
    assign w_yabs = vec_yin[DATA_WIDTH-1] ? -w_yext : w_yext;

    // One micro-rotation driven by the sign of the current y.
    always_comb begin
        w_dir    = ~r_y[CORDIC_WIDTH-1];
        w_xsh    = r_x >>> r_cnt;
        w_ysh    = r_y >>> r_cnt;
        w_atan   = atan_lut(r_cnt);
        w_rot_nx = r_rot;
        w_rot_nx[r_cnt] = w_dir;
        if (w_dir) begin
            w_xnx = r_x + w_ysh;
            w_ynx = r_y - w_xsh;
            w_znx = r_z + w_atan;
        end else begin
            w_xnx = r_x - w_ysh;
            w_ynx = r_y + w_xsh;
            w_znx = r_z - w_atan;
        end
    end

    assign w_prod = r_x * K_GAIN;
    assign w_scl  = SCL_W'(w_prod >>> 20);

    // Gain compensation with clamping into the non-negative Q16.16 range.
    always_comb begin
        if (w_scl[SCL_W-1]) begin
            w_mag = '0;
        end else if (|w_scl[SCL_W-2:DATA_WIDTH-1]) begin
            w_mag = POS_MAX;
        end else begin
            w_mag = w_scl[DATA_WIDTH-1:0];
        end
    end

    // Map the first-quadrant angle back to the input quadrant.
    always_comb begin
        unique case (r_quad)
            2'b00:   w_ang = r_z;
            2'b10:   w_ang = HALF_TURN - r_z;
            2'b01:   w_ang = -r_z;
            default: w_ang = r_z - HALF_TURN;
        endcase
    end

    // Request FSM: accept, iterate, compensate, with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_z        <= '0;
            r_cnt      <= '0;
            r_rot      <= '0;
            r_quad     <= '0;
            r_aen      <= 1'b0;
            r_zero     <= 1'b0;
            r_busy     <= 1'b0;
            r_opvld    <= 1'b0;
            r_start    <= 1'b0;
            r_xout     <= '0;
            r_rot_out  <= '0;
            r_quad_out <= '0;
            r_ang_out  <= '0;
        end else begin
            r_opvld <= 1'b0;
            r_start <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (vec_en) begin
                        r_x     <= w_xabs <<< FRAC;
                        r_y     <= w_yabs <<< FRAC;
                        r_z     <= '0;
                        r_cnt   <= '0;
                        r_rot   <= '0;
                        r_quad  <= {vec_xin[DATA_WIDTH-1],
                                    vec_yin[DATA_WIDTH-1]};
                        r_aen   <= vec_angle_calc_en;
                        r_zero  <= (vec_xin == '0) && (vec_yin == '0);
                        r_busy  <= 1'b1;
                        r_state <= ITER;
                    end
                end
                ITER: begin
                    r_x   <= w_xnx;
                    r_y   <= w_ynx;
                    r_z   <= w_znx;
                    r_rot <= w_rot_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_rot_out  <= w_rot_nx;
                        r_quad_out <= r_quad;
                        r_start    <= 1'b1;
                        r_state    <= COMP;
                    end
                end
                COMP: begin
                    r_xout    <= w_mag;
                    r_ang_out <= (r_aen && !r_zero) ? w_ang : '0;
                    r_opvld   <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy                   = r_busy;
    assign vec_opvld              = r_opvld;
    assign vec_xout               = r_xout;
    assign vec_microRot_out       = r_rot_out;
    assign vec_microRot_out_start = r_start;
    assign vec_quad_out           = r_quad_out;
    assign vec_angle_out          = r_ang_out;

endmodule

// File: doc/cordic_vec_responder.md
Name: cordic_vec_responder

Overview:
- Iterative vectoring-mode CORDIC responder.
- Serves the ICA vectoring request channel used by the norm_Nd initiators: accepts an (x, y) pair, returns the gain-compensated magnitude, the micro-rotation direction word, the quadrant code and an optional angle.
- The microRot/quad outputs feed a rotation unit so that it can replay the same rotation on other vector pairs.
- Single-lane unit with one rotation per clock. It is the lightweight counterpart to the shared wrapper for per-block instantiation.

Parameters:
DATA_WIDTH, 32, signed Q16.16 input/output sample width
CORDIC_WIDTH, 38, internal datapath width (DATA_WIDTH + 2 guard MSBs + 4 fraction LSBs)
CORDIC_STAGES, 16, number of micro-rotations
ANGLE_WIDTH, 16, signed angle width; 2^(ANGLE_WIDTH-1) = pi rad

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
vec_en  in  1  request strobe, one cycle; accepted only when busy=0
vec_xin  in  DATA_WIDTH  signed x operand
vec_yin  in  DATA_WIDTH  signed y operand
vec_angle_calc_en  in  1  sampled with vec_en; 1 = produce angle_out
busy  out  1  request in progress
vec_opvld  out  1  one-cycle result-valid pulse
vec_xout  out  DATA_WIDTH  gain-compensated magnitude, Q16.16, non-negative
vec_microRot_out  out  CORDIC_STAGES  bit i = direction of iteration i (1 = clockwise, y_i >= 0)
vec_microRot_out_start  out  1  one-cycle pulse: microRot_out/quad_out now valid
vec_quad_out  out  2  {xin<0, yin<0}
vec_angle_out  out  ANGLE_WIDTH  atan2(yin, xin), scaled so that pi = 2^(ANGLE_WIDTH-1)

Behaviour:
- Reset: all outputs 0, FSM to IDLE. This applies mid-operation as well: the in-flight request is discarded and no opvld is issued.
- FSM IDLE -> ITER -> COMP -> IDLE.
- Accept (IDLE, vec_en=1, edge E):
  - Latch quad = {xin[MSB], yin[MSB]} and the angle_calc_en flag.
  - x0 = |xin|, y0 = |yin|, sign-extended to CORDIC_WIDTH and shifted left by 4.
  - |0x80000000| = +2^31, representable.
  - busy = 1 from E.
- ITER, counter i = 0..CORDIC_STAGES-1, one per edge:
  - If y_i >= 0: x += y>>>i, y -= x>>>i, z += ATAN[i], microRot[i] = 1.
  - Else: x -= y>>>i, y += x>>>i, z -= ATAN[i], microRot[i] = 0.
  - Shifts are arithmetic; all updates use the old values.
  - ATAN[i] = round(atan(2^-i) / pi * 2^(ANGLE_WIDTH-1)); ATAN[0] = 8192.
- At edge E+CORDIC_STAGES:
  - microRot_out and quad_out are registered and held until the next accept.
  - vec_microRot_out_start pulses for that one cycle.
  - FSM moves to COMP.
- COMP (edge E+CORDIC_STAGES+1):
  - xout = (x_N * 16'h9B75) >>> 20, i.e. K = 0.607253 with the 4 guard fraction bits removed; truncation toward negative infinity.
  - Saturate to 0x7FFFFFFF if the result exceeds the positive maximum.
  - vec_opvld pulses for one cycle; busy drops in the same cycle. A new vec_en is accepted on the next edge.
- Latency: opvld is high in the cycle following edge E+CORDIC_STAGES+1, i.e. CORDIC_STAGES+2 = 18 cycles after vec_en is sampled.
- Angle reconstruction from first-quadrant z, computed modulo 2^ANGLE_WIDTH:
  - quad 00: z
  - quad 10: 2^(ANGLE_WIDTH-1) - z
  - quad 01: -z
  - quad 11: z - 2^(ANGLE_WIDTH-1)
- If angle_calc_en was 0, angle_out = 0.
- Zero input (xin = yin = 0): microRot all ones, xout = 0, angle_out = 0 (forced).
- vec_en while busy: ignored, with no effect on the in-flight operation or the outputs.
- vec_en in the cycle busy falls: accepted only if the FSM is in IDLE at that edge. There is no queueing.
- Results (xout, angle, microRot, quad) hold until the next accept or reset.

Test Plan:
1. Reset held 3 cycles, then released -> all outputs 0, busy=0, no opvld.
2. xin=0x00030000, yin=0x00040000, angle_calc_en=1:
   - opvld exactly 18 cycles after vec_en.
   - xout = 0x00050000 ±8 LSB.
   - quad = 00, angle_out = 9672 ±2.
   - microRot_out_start one cycle before opvld.
3. xin=0xFFFD0000 (-3), yin=0x00040000 -> quad = 10, angle_out = 23096 ±2, xout ≈ 0x00050000, microRot_out identical to scenario 2.
4. xin=0x80000000, yin=0 -> xout = 0x7FFFFFFF (saturated), quad = 10. Then xin = yin = 0 -> xout = 0, angle_out = 0, microRot_out = 0xFFFF.
5. vec_en pulsed with (1.0, 0) while busy, 5 cycles into a (3, 4) request -> only one opvld; results match scenario 2.
6. reset asserted 8 cycles into a request -> no opvld, outputs 0. A fresh request after reset completes normally with 18-cycle latency.
